sa_operand_loader: RTL

- Upstream feeder for the systolic-array enable generator (PE_config).
- On start, reads matrix A (X×N, row-major) and matrix B (N×Y, column-major) from two synchronous read memories.
- Drives the contiguous Xin_val/Xin_data and Yin_val/Yin_data streams the enable generator and input FIFOs expect, then waits for cal_done and reports job completion.

---
 rtl/sa_pkg.sv | 10 +
 rtl/sa_operand_loader_if.sv | 17 +
 rtl/sa_stream_reader.sv | 52 +++++
 rtl/sa_operand_loader.sv | 57 +++++
 4 files changed

// File: rtl/sa_pkg.sv
// sa_pkg: shared FSM encoding, pipeline constants and counter-width helper
// for the systolic-array operand loader.
package sa_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_CAL, DONE} state_t;
  localparam int RD_LAT = 2;
  localparam int IDLE_GAP = 3;
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/sa_operand_loader_if.sv
// sa_operand_loader_if: job control, operand memory ports and west/north streams.
interface sa_operand_loader_if #(
  parameter int IN_LEN = 8,
  parameter int ADDR_WIDTH = 8
);
  logic start, busy, done, a_rd_en, b_rd_en, Xin_val, Yin_val, cal_done;
  logic [ADDR_WIDTH-1:0] a_base, b_base, a_addr, b_addr;
  logic [IN_LEN-1:0] a_rdata, b_rdata, Xin_data, Yin_data;
  modport master (
    input start, a_base, b_base, a_rdata, b_rdata, cal_done,
    output busy, done, a_rd_en, a_addr, b_rd_en, b_addr, Xin_val, Xin_data, Yin_val, Yin_data
  );
  modport slave (
    output start, a_base, b_base, a_rdata, b_rdata, cal_done,
    input busy, done, a_rd_en, a_addr, b_rd_en, b_addr, Xin_val, Xin_data, Yin_val, Yin_data
  );
endinterface

// File: rtl/sa_stream_reader.sv
// sa_stream_reader: address counter plus read-latency pipeline for one operand
// memory, producing a gap-free valid/data stream of LEN words.
module sa_stream_reader
  import sa_pkg::*;
#(
  parameter int LEN = 9,
  parameter int IN_LEN = 8,
  parameter int AW = 8,
  parameter int CW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              run,
  input  logic [AW-1:0]     base,
  output logic              rd_en,
  output logic [AW-1:0]     addr,
  input  logic [IN_LEN-1:0] rdata,
  output logic              val,
  output logic [IN_LEN-1:0] data,
  output logic              drained
);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] base_q, base_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [IN_LEN-1:0] data_q, data_d;
  always_comb begin
    rd_en = run && cnt_q < CW'(LEN);
    addr = base_q + AW'(cnt_q);
    cnt_d = clear ? '0 : cnt_q + CW'(rd_en);
    base_d = clear ? base : base_q;
    vld_d = {vld_q[RD_LAT-2:0], rd_en};
    data_d = vld_q[RD_LAT-2] ? rdata : data_q;
    // drained one cycle early so the stream valid is already low in the next state
    drained = cnt_q == CW'(LEN) && vld_q[RD_LAT-2:0] == '0;
    val = vld_q[RD_LAT-1];
    data = data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      base_q <= '0;
      vld_q <= '0;
      data_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      base_q <= base_d;
      vld_q <= vld_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/sa_operand_loader.sv
// sa_operand_loader: streams A (row-major) and B (column-major) operands to the
// systolic-array enable generator, then waits for cal_done to complete the job.
module sa_operand_loader
  import sa_pkg::*;
#(
  parameter int X = 3,
  parameter int N = 3,
  parameter int Y = 3,
  parameter int IN_LEN = 8,
  parameter int ADDR_WIDTH = 8
) (
  input logic clk,
  input logic sys_rst_n,
  sa_operand_loader_if.master bus
);
  localparam int CW = cnt_width(X * N, N * Y);
  state_t state_q, state_d;
  logic busy_q, busy_d, done_q, done_d, cal_seen_q, cal_seen_d;
  logic accept, run, a_drained, b_drained;
  always_comb begin
    accept = state_q == IDLE && bus.start;
    run = state_q == LOAD;
    state_d = state_q == IDLE ? (bus.start ? LOAD : IDLE)
            : state_q == LOAD ? (a_drained && b_drained ? WAIT_CAL : LOAD)
            : state_q == WAIT_CAL ? (bus.cal_done || cal_seen_q ? DONE : WAIT_CAL)
            : IDLE;
    busy_d = state_d == LOAD || state_d == WAIT_CAL;
    done_d = state_d == DONE;
    // an early cal_done during LOAD must not be lost
    cal_seen_d = !accept && (cal_seen_q || (state_q != IDLE && bus.cal_done));
  end
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cal_seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cal_seen_q <= cal_seen_d;
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  sa_stream_reader #(.LEN(X * N), .IN_LEN(IN_LEN), .AW(ADDR_WIDTH), .CW(CW)) u_a (
    .clk(clk), .rst_n(sys_rst_n), .clear(accept), .run(run), .base(bus.a_base),
    .rd_en(bus.a_rd_en), .addr(bus.a_addr), .rdata(bus.a_rdata),
    .val(bus.Xin_val), .data(bus.Xin_data), .drained(a_drained)
  );
  sa_stream_reader #(.LEN(N * Y), .IN_LEN(IN_LEN), .AW(ADDR_WIDTH), .CW(CW)) u_b (
    .clk(clk), .rst_n(sys_rst_n), .clear(accept), .run(run), .base(bus.b_base),
    .rd_en(bus.b_rd_en), .addr(bus.b_addr), .rdata(bus.b_rdata),
    .val(bus.Yin_val), .data(bus.Yin_data), .drained(b_drained)
  );
endmodule
